// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, default parameters and helpers for the FIR MAC engine
package fir_pkg;

  localparam int DEF_DW     = 32;
  localparam int DEF_CW     = 32;
  localparam int DEF_AW     = 32;
  localparam int DEF_NTAP   = 11;
  localparam int DEF_SAT_EN = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } fir_state_t;

  // Ceiling log2; clog2(1) = 0 so a single-tap engine needs no guard bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_sat.sv
// rtl/fir_mac_sat.sv - reduces the full-precision sum to the output width with overflow flag
module fir_mac_sat
  import fir_pkg::*;
#(
  parameter int ACC_W  = 75,
  parameter int AW     = DEF_AW,
  parameter int SAT_EN = DEF_SAT_EN
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [AW-1:0]    y_data,
  output logic                    ovf
);

  generate
    if (ACC_W > AW) begin : g_narrow
      localparam logic [AW-1:0] NEG_MIN = AW'(1) << (AW - 1);
      localparam logic [AW-1:0] POS_MAX = ~NEG_MIN;

      // The sum fits in AW signed bits only when every bit above the AW-bit
      // sign position repeats that sign bit.
      logic [ACC_W-AW:0] top_bits;
      assign top_bits = sum[ACC_W-1:AW-1];
      assign ovf      = !((&top_bits) || !(|top_bits));

      // Wrap by default; clamp toward the sign of the true sum when saturating.
      always_comb begin
        y_data = sum[AW-1:0];
        if ((SAT_EN != 0) && ovf) begin
          y_data = sum[ACC_W-1] ? NEG_MIN : POS_MAX;
        end
      end
    end else begin : g_wide
      // Output is at least as wide as the accumulator: sign-extend, never overflows.
      assign ovf    = 1'b0;
      assign y_data = AW'(sum);
    end
  endgenerate

endmodule

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - streaming multiply-accumulate engine producing one result per NTAP pairs
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int CW     = DEF_CW,
  parameter int AW     = DEF_AW,
  parameter int NTAP   = DEF_NTAP,
  parameter int SAT_EN = DEF_SAT_EN
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_data,
  input  logic [CW-1:0] tap_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] y_data,
  output logic          out_ovf,
  output logic          busy
);

  localparam int PW    = DW + CW;
  localparam int ACC_W = PW + clog2(NTAP);
  localparam int CNT_W = clog2(NTAP + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NTAP);

  fir_state_t state;

  logic signed [PW-1:0]    x_ext;
  logic signed [PW-1:0]    t_ext;
  logic signed [PW-1:0]    product;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_base;
  logic [CNT_W-1:0]        count_inc;
  logic                    accept;
  logic                    frame_done;
  logic [AW-1:0]           sat_y;
  logic                    sat_ovf;

  // Full-precision signed product: both operands sign-extended to the product width.
  assign x_ext   = {{CW{x_data[DW-1]}}, x_data};
  assign t_ext   = {{DW{tap_data[CW-1]}}, tap_data};
  assign product = x_ext * t_ext;

  // A pair accepted outside ACCUM always opens a fresh frame, so the running
  // sum and count only carry over while accumulating.
  assign acc_base   = (state == ACCUM) ? acc : '0;
  assign acc_sum    = acc_base + ACC_W'(product);
  assign count_base = (state == ACCUM) ? count : '0;
  assign count_inc  = count_base + CNT_W'(1);
  assign frame_done = (count_inc == CNT_LAST);

  // Holding a result only lets a new pair in when the consumer drains it in
  // the same cycle; reset and clear block acceptance outright.
  assign in_ready = !Reset && !clear && ((state != HOLD) || out_ready);
  assign accept   = in_valid && in_ready;

  // The result path sees the sum including the current product so the output
  // register can capture it on the final accept.
  fir_mac_sat #(
    .ACC_W (ACC_W),
    .AW    (AW),
    .SAT_EN(SAT_EN)
  ) u_sat (
    .sum   (acc_sum),
    .y_data(sat_y),
    .ovf   (sat_ovf)
  );

  // Frame FSM with registered result, valid and busy outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      y_data    <= '0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      y_data    <= '0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      acc   <= acc_sum;
      count <= count_inc;
      busy  <= 1'b1;
      if (frame_done) begin
        state     <= HOLD;
        out_valid <= 1'b1;
        y_data    <= sat_y;
        out_ovf   <= sat_ovf;
      end else begin
        state     <= ACCUM;
        out_valid <= 1'b0;
      end
    end else if ((state == HOLD) && out_ready) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - randomized self-checking bench for fir_mac_engine
module tb_fir_mac_engine;

  localparam int NTAP = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] x_data;
  logic [31:0] tap_data;
  logic [31:0] y_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ovf;
  logic        busy;

  logic [15:0] x16;
  logic [15:0] t16;
  logic [15:0] y_sat;
  logic [15:0] y_wrap;
  logic        rdy_s, rdy_w, ov_s, ov_w, ovf_s, ovf_w, busy_s, busy_w;

  int tests = 0;
  int fails = 0;

  logic signed [127:0] m_sum;
  int                  m_cnt;
  logic [32:0]         expq[$];

  always #5 clk = ~clk;

  fir_mac_engine dut (
    .CLK(clk), .Reset(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .x_data(x_data), .tap_data(tap_data), .out_valid(out_valid), .out_ready(out_ready),
    .y_data(y_data), .out_ovf(out_ovf), .busy(busy)
  );

  fir_mac_engine #(.DW(16), .CW(16), .AW(16), .NTAP(11), .SAT_EN(1)) u_sat (
    .CLK(clk), .Reset(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_s),
    .x_data(x16), .tap_data(t16), .out_valid(ov_s), .out_ready(out_ready),
    .y_data(y_sat), .out_ovf(ovf_s), .busy(busy_s)
  );

  fir_mac_engine #(.DW(16), .CW(16), .AW(16), .NTAP(11), .SAT_EN(0)) u_wrap (
    .CLK(clk), .Reset(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_w),
    .x_data(x16), .tap_data(t16), .out_valid(ov_w), .out_ready(out_ready),
    .y_data(y_wrap), .out_ovf(ovf_w), .busy(busy_w)
  );

  function automatic logic signed [127:0] prod(input logic [31:0] x, input logic [31:0] t,
                                               input int w);
    logic signed [127:0] a, b;
    if (w == 16) begin
      a = $signed(x[15:0]);
      b = $signed(t[15:0]);
    end else begin
      a = $signed(x);
      b = $signed(t);
    end
    return a * b;
  endfunction

  // Result of a frame sum as {ovf, y}: y masked to aw bits.
  function automatic logic [32:0] model_result(input logic signed [127:0] sum, input int aw,
                                               input bit sat);
    logic signed [127:0] maxv, minv;
    logic [31:0] y;
    logic ovf;
    maxv = (128'sd1 <<< (aw - 1)) - 128'sd1;
    minv = -(128'sd1 <<< (aw - 1));
    ovf  = (sum > maxv) || (sum < minv);
    if (sat && (sum > maxv))      y = maxv[31:0];
    else if (sat && (sum < minv)) y = minv[31:0];
    else                          y = sum[31:0];
    if (aw < 32) y = y & ((32'd1 << aw) - 32'd1);
    return {ovf, y};
  endfunction

  task automatic model_reset();
    m_sum = '0;
    m_cnt = 0;
    expq.delete();
  endtask

  task automatic model_accept(input logic [31:0] x, input logic [31:0] t, output bit done);
    m_sum += prod(x, t, 32);
    m_cnt++;
    done = 1'b0;
    if (m_cnt == NTAP) begin
      expq.push_back(model_result(m_sum, 32, 1'b0));
      m_sum = '0;
      m_cnt = 0;
      done  = 1'b1;
    end
  endtask

  // One clock: drive at the negedge, observe handshakes 1ns later, end at next negedge.
  task automatic step(input logic v, input logic [31:0] x, input logic [31:0] t,
                      input logic ordy, output logic acc, output logic took,
                      output logic [31:0] ty, output logic tovf);
    in_valid  = v;
    x_data    = x;
    tap_data  = t;
    x16       = x[15:0];
    t16       = t[15:0];
    out_ready = ordy;
    #1;
    acc  = in_valid && in_ready;
    took = out_valid && out_ready;
    ty   = y_data;
    tovf = out_ovf;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    x_data = 32'd5; tap_data = 32'd7; x16 = 16'd5; t16 = 16'd7;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if ({out_valid, busy, out_ovf, y_data} !== 35'd0) begin
      fails++;
      $display("FAIL reset_state: valid=%b busy=%b ovf=%b y=%h want all 0",
               out_valid, busy, out_ovf, y_data);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL idle_in_ready: got %b want 1", in_ready);
    end
  endtask

  // Fixed frame with constant tap; also checks the output appears exactly one cycle late.
  task automatic test_fixed_frame(input string name, input int x0, input int xstep,
                                  input logic [31:0] tap);
    logic a, tk, tovf;
    logic [31:0] ty, xv;
    bit done;
    int nacc;
    do_reset();
    model_reset();
    nacc = 0;
    for (int k = 0; k < NTAP; k++) begin
      xv = 32'(x0 + k * xstep);
      step(1'b1, xv, tap, 1'b0, a, tk, ty, tovf);
      if (a) begin nacc++; model_accept(xv, tap, done); end
      if (k == NTAP - 2) begin
        tests++;
        if (out_valid !== 1'b0) begin
          fails++; $display("FAIL %s_early_valid: got %b want 0", name, out_valid);
        end
      end
    end
    tests++;
    if (nacc != NTAP || out_valid !== 1'b1 || busy !== 1'b1 || expq.size() != 1) begin
      fails++;
      $display("FAIL %s_latency: accepts=%0d valid=%b busy=%b want %0d,1,1",
               name, nacc, out_valid, busy, NTAP);
    end else begin
      tests++;
      if ({out_ovf, y_data} !== expq[0]) begin
        fails++;
        $display("FAIL %s_value: got ovf=%b y=%h want ovf=%b y=%h",
                 name, out_ovf, y_data, expq[0][32], expq[0][31:0]);
      end
    end
  endtask

  task automatic test_sat16();
    logic a, tk, tovf;
    logic [31:0] ty;
    logic signed [127:0] s16;
    logic [32:0] es, ew;
    do_reset();
    s16 = '0;
    for (int k = 0; k < NTAP; k++) begin
      step(1'b1, 32'h7FFF, 32'h7FFF, 1'b0, a, tk, ty, tovf);
      s16 += prod(32'h7FFF, 32'h7FFF, 16);
    end
    es = model_result(s16, 16, 1'b1);
    ew = model_result(s16, 16, 1'b0);
    tests++;
    if (ov_s !== 1'b1 || {ovf_s, y_sat} !== {es[32], es[15:0]}) begin
      fails++;
      $display("FAIL sat16: valid=%b ovf=%b y=%h want 1 %b %h", ov_s, ovf_s, y_sat, es[32], es[15:0]);
    end
    tests++;
    if (ov_w !== 1'b1 || {ovf_w, y_wrap} !== {ew[32], ew[15:0]}) begin
      fails++;
      $display("FAIL wrap16: valid=%b ovf=%b y=%h want 1 %b %h", ov_w, ovf_w, y_wrap, ew[32], ew[15:0]);
    end
  endtask

  task automatic test_random();
    logic a, tk, tovf;
    logic [31:0] ty, xv, tv;
    logic [32:0] e;
    bit done, big;
    int got;
    do_reset();
    model_reset();
    got = 0;
    big = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (m_cnt == 0) big = $urandom_range(0, 1) != 0;
      xv = big ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
      tv = big ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
      step($urandom_range(0, 3) != 0, xv, tv, $urandom_range(0, 2) != 0, a, tk, ty, tovf);
      if (tk) begin
        tests++;
        if (expq.size() == 0) begin
          fails++; $display("FAIL rand_spurious: result y=%h with none expected", ty);
        end else begin
          e = expq.pop_front();
          got++;
          if ({tovf, ty} !== e) begin
            fails++;
            $display("FAIL rand_result%0d: got ovf=%b y=%h want ovf=%b y=%h",
                     got, tovf, ty, e[32], e[31:0]);
          end
        end
      end
      if (a) begin
        model_accept(xv, tv, done);
        if (done) begin
          tests++;
          if (out_valid !== 1'b1) begin
            fails++; $display("FAIL rand_latency: out_valid=%b want 1", out_valid);
          end
        end
      end
    end
    for (int c = 0; c < 4 && expq.size() != 0; c++) begin
      step(1'b0, 32'd0, 32'd0, 1'b1, a, tk, ty, tovf);
      if (tk) begin
        e = expq.pop_front();
        tests++;
        if ({tovf, ty} !== e) begin
          fails++;
          $display("FAIL rand_drain: got ovf=%b y=%h want ovf=%b y=%h", tovf, ty, e[32], e[31:0]);
        end
      end
    end
    tests++;
    if (expq.size() != 0 || got == 0) begin
      fails++; $display("FAIL rand_count: pending=%0d delivered=%0d want 0 pending", expq.size(), got);
    end
  endtask

  task automatic test_back_to_back();
    logic a, tk, tovf;
    logic [31:0] ty, xv, tv, held;
    logic [32:0] e;
    bit done;
    int got, gaps, unstable;
    do_reset();
    model_reset();
    for (int k = 0; k < NTAP; k++) begin
      xv = $urandom; tv = $urandom;
      step(1'b1, xv, tv, 1'b0, a, tk, ty, tovf);
      if (a) model_accept(xv, tv, done);
    end
    held = y_data;
    unstable = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, $urandom, $urandom, 1'b0, a, tk, ty, tovf);
      if (a || out_valid !== 1'b1 || y_data !== held) unstable++;
    end
    tests++;
    if (unstable != 0 || expq.size() != 1) begin
      fails++; $display("FAIL hold_stall: bad cycles=%0d results=%0d want 0,1", unstable, expq.size());
    end else begin
      tests++;
      if ({out_ovf, y_data} !== expq[0]) begin
        fails++;
        $display("FAIL hold_value: got ovf=%b y=%h want ovf=%b y=%h",
                 out_ovf, y_data, expq[0][32], expq[0][31:0]);
      end
    end
    got = 0; gaps = 0;
    for (int k = 0; k < 2 * NTAP + 4; k++) begin
      if (k < 2 * NTAP) begin
        xv = $urandom; tv = $urandom;
        step(1'b1, xv, tv, 1'b1, a, tk, ty, tovf);
        if (!a) gaps++;
        else model_accept(xv, tv, done);
      end else begin
        step(1'b0, 32'd0, 32'd0, 1'b1, a, tk, ty, tovf);
      end
      if (tk) begin
        got++;
        tests++;
        if (expq.size() == 0) begin
          fails++; $display("FAIL b2b_spurious: result y=%h with none expected", ty);
        end else begin
          e = expq.pop_front();
          if ({tovf, ty} !== e) begin
            fails++;
            $display("FAIL b2b_result%0d: got ovf=%b y=%h want ovf=%b y=%h",
                     got, tovf, ty, e[32], e[31:0]);
          end
        end
      end
    end
    tests++;
    if (gaps != 0 || got != 3) begin
      fails++; $display("FAIL b2b_flow: in_ready gaps=%0d results=%0d want 0,3", gaps, got);
    end
  endtask

  // Partial frame then clear (use_reset=0) or Reset (use_reset=1); next frame must be clean.
  task automatic test_abort(input string name, input bit use_reset);
    logic a, tk, tovf;
    logic [31:0] ty;
    bit done;
    do_reset();
    model_reset();
    for (int k = 0; k < 5; k++) step(1'b1, $urandom, $urandom, 1'b1, a, tk, ty, tovf);
    if (use_reset) rst = 1'b1; else clear = 1'b1;
    step(1'b1, $urandom, $urandom, 1'b1, a, tk, ty, tovf);
    rst = 1'b0; clear = 1'b0;
    tests++;
    if (a !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL %s_discard: accepted=%b busy=%b valid=%b want 0,0,0", name, a, busy, out_valid);
    end
    for (int k = 0; k < NTAP; k++) begin
      step(1'b1, 32'd1, 32'd1, 1'b0, a, tk, ty, tovf);
      if (a) model_accept(32'd1, 32'd1, done);
    end
    tests++;
    if (expq.size() != 1 || out_valid !== 1'b1 || {out_ovf, y_data} !== expq[0]) begin
      fails++;
      $display("FAIL %s_fresh: valid=%b ovf=%b y=%h want 1 with sum of fresh frame only",
               name, out_valid, out_ovf, y_data);
    end
    clear = 1'b1;
    step(1'b0, 32'd0, 32'd0, 1'b0, a, tk, ty, tovf);
    clear = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL %s_clear_hold: valid=%b busy=%b want 0,0", name, out_valid, busy);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_data = '0; tap_data = '0; x16 = '0; t16 = '0;
    @(negedge clk);
    test_reset();
    test_fixed_frame("ramp", 1, 1, 32'd1);
    test_fixed_frame("neg", -2, 0, 32'd3);
    test_sat16();
    test_random();
    test_back_to_back();
    test_abort("clear", 1'b0);
    test_abort("reset", 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
